dff_chain: RTL and testbench
============================

DFF_CHAIN -- requirements
Module: dff_chain

Interface
REQ-001 Parameter WIDTH, default 8, data width of each stage in bits (legal range 1 to 64).
REQ-002 Parameter DEPTH, default 4, number of register stages (legal range 2 to 32).
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the FILL port.
REQ-004 Port C, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 Port RN, input, 1 bit, asynchronous active-low reset.
REQ-006 Port EN, input, 1 bit, clock enable; when low, all state holds.
REQ-007 Port CLR, input, 1 bit, synchronous clear; it has priority over EN and MODE.
REQ-008 Port MODE, input, 2 bits: 00 hold, 01 shift, 10 parallel load, 11 rotate.
REQ-009 Port D, input, WIDTH bits, serial data into stage 0.
REQ-010 Port DV, input, 1 bit, valid flag accompanying D.
REQ-011 Port LD, input, WIDTH*DEPTH bits, parallel load data; slice i (bits i*WIDTH to i*WIDTH+WIDTH-1) loads stage i.
REQ-012 Port Q, output, WIDTH bits, contents of stage DEPTH-1.
REQ-013 Port QV, output, 1 bit, valid flag of stage DEPTH-1.
REQ-014 Port FILL, output, CW bits, number of stages whose valid flag is set.
REQ-015 Port FULL, output, 1 bit, high when FILL equals DEPTH.

Function
REQ-016 Each stage i SHALL hold a WIDTH-bit value s[i] and a valid bit v[i].
REQ-017 If CLR is high at a rising edge, all s[i] and v[i] SHALL become 0, regardless of EN and MODE.
REQ-018 If CLR is low and EN is low, all state SHALL hold.
REQ-019 MODE 00 with EN high SHALL hold all state.
REQ-020 MODE 01 (shift) SHALL load s[0] from D and v[0] from DV, and load stage i from stage i-1 for i = 1 to DEPTH-1; the outgoing stage DEPTH-1 value is discarded.
REQ-021 MODE 10 (load) SHALL load every s[i] from slice i of LD and set every v[i] to 1 in the same cycle.
REQ-022 MODE 11 (rotate) SHALL load stage 0 from stage DEPTH-1 (data and valid), and stage i from stage i-1; FILL is unchanged.
REQ-023 Q, QV, FILL and FULL SHALL all be registered; none has a combinational path from any input.
REQ-024 FILL SHALL equal the population count of the v bits present after each edge.
REQ-025 Shift latency SHALL be DEPTH cycles: a D/DV pair sampled at edge k appears on Q/QV after edge k+DEPTH-1, provided EN is high and MODE is 01 at every intervening edge.
REQ-026 Shifting with DV=1 while FULL is high SHALL keep FILL at DEPTH; the tail word is dropped and no error is flagged.
REQ-027 Shifting with DV=0 SHALL inject a bubble, and FILL SHALL drop by the outgoing QV.
REQ-028 Any MODE change between cycles SHALL take effect at the next edge without stalls or dead cycles.

Reset
REQ-029 While RN is low, all s[i], v[i], Q, QV, FILL and FULL SHALL be 0 immediately, independent of C.
REQ-030 Reset asserted mid-shift or mid-load SHALL discard all in-flight data.
REQ-031 The first state update after RN deasserts SHALL occur on the first rising edge of C with RN high.

Structure
REQ-032 Package dff_pkg SHALL hold the MODE encodings (MODE_HOLD, MODE_SHIFT, MODE_LOAD, MODE_ROT) and the mode typedef.
REQ-033 Sub-module dff_stage (one WIDTH-bit stage plus its valid bit, with enable, clear and a 3-way next-value select) SHALL be instantiated DEPTH times.
REQ-034 The FILL counter SHALL live in dff_chain and be updated incrementally, not by a full recount.

Verification (WIDTH=8, DEPTH=4)
REQ-035 Reset: RN=0 with LD loaded beforehand -> Q=0, QV=0, FILL=0, FULL=0 immediately, before any clock edge.
REQ-036 Shift latency: shift D=11,22,33,44 with DV=1 -> Q=11 and QV=1 after the 4th edge, FULL=1; one more shift with D=55 -> Q=22, FILL=4.
REQ-037 Load then rotate: LD=44_33_22_11 with MODE 10 -> Q=44, FILL=4; one rotate -> Q=33 and stage 0 holds 44; four rotates total -> Q=44 again.
REQ-038 Bubbles and EN: shift pattern DV=1,0,1,0 -> FILL=2; then EN=0 for 3 cycles -> all outputs unchanged.
REQ-039 Priority: CLR=1 together with MODE 10 -> FILL=0, QV=0; CLR=1 with EN=0 -> state still cleared.
REQ-040 Mid-operation reset: RN pulsed low between edges during a shift -> outputs 0 at once; shifting resumes correctly from the first edge with RN high.

Source files
------------

// File: rtl/dff_pkg.sv
// dff_pkg: shared encodings for the dff_chain block.
//   mode_e : external MODE port encoding (hold / shift / load / rotate)
//   sel_e  : per-stage next-value select driven by dff_chain into dff_stage
package dff_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_SHIFT = 2'b01,
    MODE_LOAD  = 2'b10,
    MODE_ROT   = 2'b11
  } mode_e;

  // Shift and rotate both take the upstream neighbour; they differ only in
  // what feeds stage 0, which the top resolves before the stages see it.
  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_CHAIN = 2'b01,
    SEL_LOAD  = 2'b10
  } sel_e;

endpackage

// File: rtl/dff_stage.sv
// dff_stage: one WIDTH-bit register stage plus its valid bit.
//   C, RN         : clock, async active-low reset
//   en, clr       : clock enable, synchronous clear (clr wins over en)
//   sel           : next-value select (hold / upstream chain / parallel load)
//   chain_d/v     : upstream data/valid
//   load_d        : parallel load data (valid forced to 1 on load)
//   s, v          : stage contents
module dff_stage
  import dff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             C,
  input  logic             RN,
  input  logic             en,
  input  logic             clr,
  input  sel_e             sel,
  input  logic [WIDTH-1:0] chain_d,
  input  logic             chain_v,
  input  logic [WIDTH-1:0] load_d,
  output logic [WIDTH-1:0] s,
  output logic             v
);

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      s <= '0;
      v <= 1'b0;
    end else if (clr) begin
      s <= '0;
      v <= 1'b0;
    end else if (en) begin
      case (sel)
        SEL_CHAIN: begin
          s <= chain_d;
          v <= chain_v;
        end
        SEL_LOAD: begin
          s <= load_d;
          v <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dff_chain.sv
// dff_chain: DEPTH-stage WIDTH-bit register chain with valid tracking.
//   C, RN : clock, async active-low reset
//   EN    : clock enable; CLR : synchronous clear (beats EN and MODE)
//   MODE  : 00 hold, 01 shift, 10 parallel load, 11 rotate
//   D, DV : serial data/valid into stage 0
//   LD    : parallel load, slice i -> stage i
//   Q, QV : tail stage data/valid (straight from the stage flops)
//   FILL  : count of valid stages; FULL : FILL == DEPTH (both registered)
module dff_chain
  import dff_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   C,
  input  logic                   RN,
  input  logic                   EN,
  input  logic                   CLR,
  input  logic [1:0]             MODE,
  input  logic [WIDTH-1:0]       D,
  input  logic                   DV,
  input  logic [WIDTH*DEPTH-1:0] LD,
  output logic [WIDTH-1:0]       Q,
  output logic                   QV,
  output logic [CW-1:0]          FILL,
  output logic                   FULL
);

  mode_e                         mode;
  sel_e                          sel;
  logic [DEPTH-1:0][WIDTH-1:0]   s;
  logic [DEPTH-1:0]              v;
  logic [DEPTH-1:0][WIDTH-1:0]   chain_d;
  logic [DEPTH-1:0]              chain_v;
  logic [CW-1:0]                 fill_nxt;

  assign mode = mode_e'(MODE);

  always_comb begin
    sel = SEL_HOLD;
    case (mode)
      MODE_SHIFT, MODE_ROT: sel = SEL_CHAIN;
      MODE_LOAD:            sel = SEL_LOAD;
      default:              sel = SEL_HOLD;
    endcase
  end

  // Stage 0 takes D on shift and the tail on rotate; the rest always take
  // their upstream neighbour.
  assign chain_d[0] = (mode == MODE_ROT) ? s[DEPTH-1] : D;
  assign chain_v[0] = (mode == MODE_ROT) ? v[DEPTH-1] : DV;

  for (genvar i = 1; i < DEPTH; i++) begin : g_link
    assign chain_d[i] = s[i-1];
    assign chain_v[i] = v[i-1];
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    dff_stage #(.WIDTH(WIDTH)) u_stage (
      .C       (C),
      .RN      (RN),
      .en      (EN),
      .clr     (CLR),
      .sel     (sel),
      .chain_d (chain_d[i]),
      .chain_v (chain_v[i]),
      .load_d  (LD[i*WIDTH +: WIDTH]),
      .s       (s[i]),
      .v       (v[i])
    );
  end

  // Incremental fill: a shift gains the incoming DV and loses the outgoing
  // tail valid; rotate moves the tail valid to the head, so count is kept.
  always_comb begin
    fill_nxt = FILL;
    if (CLR) begin
      fill_nxt = '0;
    end else if (EN) begin
      case (mode)
        MODE_SHIFT: fill_nxt = FILL + CW'(DV) - CW'(v[DEPTH-1]);
        MODE_LOAD:  fill_nxt = CW'(DEPTH);
        default:    fill_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge C or negedge RN) begin
    if (!RN) begin
      FILL <= '0;
      FULL <= 1'b0;
    end else begin
      FILL <= fill_nxt;
      FULL <= (fill_nxt == CW'(DEPTH));
    end
  end

  assign Q  = s[DEPTH-1];
  assign QV = v[DEPTH-1];

endmodule

// File: tb/tb_dff_chain.sv
module tb_dff_chain;
  import dff_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                   C = 1'b0;
  logic                   RN, EN, CLR, DV;
  logic [1:0]             MODE;
  logic [WIDTH-1:0]       D;
  logic [WIDTH*DEPTH-1:0] LD;
  logic [WIDTH-1:0]       Q;
  logic                   QV;
  logic [CW-1:0]          FILL;
  logic                   FULL;

  dff_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .C(C), .RN(RN), .EN(EN), .CLR(CLR), .MODE(MODE), .D(D), .DV(DV),
    .LD(LD), .Q(Q), .QV(QV), .FILL(FILL), .FULL(FULL)
  );

  always #5 C = ~C;

  typedef struct {
    string          name;
    logic [7:0]     q;
    logic           qv;
    logic [CW-1:0]  fill;
    logic           full;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;
  int   n_run  = 0;
  int   n_fail = 0;

  // Monitor: drains the scoreboard whenever the driver marks outputs settled.
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_run++;
        if (Q !== e.q || QV !== e.qv || FILL !== e.fill || FULL !== e.full) begin
          n_fail++;
          $display("FAIL %s: got Q=%h QV=%b FILL=%0d FULL=%b, want Q=%h QV=%b FILL=%0d FULL=%b",
                   e.name, Q, QV, FILL, FULL, e.q, e.qv, e.fill, e.full);
        end
      end
    end
  end

  task automatic expect_now(input string name, input logic [7:0] q, input logic qv,
                            input int fill, input logic full);
    exp_t e;
    e.name = name; e.q = q; e.qv = qv; e.fill = CW'(fill); e.full = full;
    exp_q.push_back(e);
    ->chk_ev;
    #1;
  endtask

  // Apply inputs, take one rising edge, then queue the expected outputs.
  task automatic cyc(input string name, input logic en, input logic clr,
                     input logic [1:0] mode, input logic [7:0] d, input logic dv,
                     input logic [7:0] q, input logic qv, input int fill,
                     input logic full);
    EN = en; CLR = clr; MODE = mode; D = d; DV = dv;
    @(posedge C);
    #1;
    expect_now(name, q, qv, fill, full);
  endtask

  initial begin
    RN = 1'b0; EN = 1'b1; CLR = 1'b0; MODE = MODE_LOAD;
    D = '0; DV = 1'b0; LD = 32'h44332211;
    #1;
    expect_now("reset_immediate", 8'h00, 0, 0, 0);
    @(posedge C); #1;
    expect_now("reset_held_edge", 8'h00, 0, 0, 0);
    RN = 1'b1;

    // Shift latency and full-chain shift
    cyc("shift_11", 1, 0, MODE_SHIFT, 8'h11, 1, 8'h00, 0, 1, 0);
    cyc("shift_22", 1, 0, MODE_SHIFT, 8'h22, 1, 8'h00, 0, 2, 0);
    cyc("shift_33", 1, 0, MODE_SHIFT, 8'h33, 1, 8'h00, 0, 3, 0);
    cyc("shift_44", 1, 0, MODE_SHIFT, 8'h44, 1, 8'h11, 1, 4, 1);
    cyc("shift_full_55", 1, 0, MODE_SHIFT, 8'h55, 1, 8'h22, 1, 4, 1);

    // Load then rotate
    cyc("load", 1, 0, MODE_LOAD, 8'h00, 0, 8'h44, 1, 4, 1);
    cyc("rot1", 1, 0, MODE_ROT, 8'h00, 0, 8'h33, 1, 4, 1);
    cyc("rot2", 1, 0, MODE_ROT, 8'h00, 0, 8'h22, 1, 4, 1);
    cyc("rot3", 1, 0, MODE_ROT, 8'h00, 0, 8'h11, 1, 4, 1);
    cyc("rot4", 1, 0, MODE_ROT, 8'h00, 0, 8'h44, 1, 4, 1);

    // CLR beats MODE load
    cyc("clr_over_load", 1, 1, MODE_LOAD, 8'h00, 0, 8'h00, 0, 0, 0);

    // Bubbles
    cyc("bub_a1", 1, 0, MODE_SHIFT, 8'hA1, 1, 8'h00, 0, 1, 0);
    cyc("bub_b2", 1, 0, MODE_SHIFT, 8'hB2, 0, 8'h00, 0, 1, 0);
    cyc("bub_c3", 1, 0, MODE_SHIFT, 8'hC3, 1, 8'h00, 0, 2, 0);
    cyc("bub_d4", 1, 0, MODE_SHIFT, 8'hD4, 0, 8'hA1, 1, 2, 0);
    for (int i = 0; i < 3; i++)
      cyc("en_low_hold", 0, 0, MODE_SHIFT, 8'hFF, 1, 8'hA1, 1, 2, 0);

    // Outgoing valid drops FILL; rotate keeps it
    cyc("bubble_drop", 1, 0, MODE_SHIFT, 8'hE5, 0, 8'hB2, 0, 1, 0);
    cyc("rot_fill_kept", 1, 0, MODE_ROT, 8'h00, 0, 8'hC3, 1, 1, 0);
    cyc("mode_hold", 1, 0, MODE_HOLD, 8'h77, 1, 8'hC3, 1, 1, 0);

    // CLR with EN low still clears
    cyc("clr_en_low", 0, 1, MODE_SHIFT, 8'h00, 0, 8'h00, 0, 0, 0);

    // Mid-operation reset
    cyc("pre_rst_01", 1, 0, MODE_SHIFT, 8'h01, 1, 8'h00, 0, 1, 0);
    cyc("pre_rst_02", 1, 0, MODE_SHIFT, 8'h02, 1, 8'h00, 0, 2, 0);
    #1 RN = 1'b0;
    #1;
    expect_now("mid_reset", 8'h00, 0, 0, 0);
    RN = 1'b1;
    cyc("post_rst_03", 1, 0, MODE_SHIFT, 8'h03, 1, 8'h00, 0, 1, 0);
    cyc("post_rst_04", 1, 0, MODE_SHIFT, 8'h04, 1, 8'h00, 0, 2, 0);
    cyc("post_rst_05", 1, 0, MODE_SHIFT, 8'h05, 1, 8'h00, 0, 3, 0);
    cyc("post_rst_06", 1, 0, MODE_SHIFT, 8'h06, 1, 8'h03, 1, 4, 1);

    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Backstop so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

endmodule
